// File: rtl/memory_stage.sv
// MEM stage of the RV32I pipeline: byte-addressed little-endian data RAM with
// sized loads/stores, alignment/legality fault detection, a sticky fault record and event counters.
module memory_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MEM_ADDR_BITS = 17,
    parameter int COUNT_WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     memwritem,
    input  logic                     memreadm,
    input  logic [2:0]               funct3m,
    input  logic [ADDRESS_WIDTH-1:0] aluresultm,
    input  logic [DATA_WIDTH-1:0]    writedatam,
    output logic [DATA_WIDTH-1:0]    readdatam,
    output logic                     fault_m,
    output logic                     fault_sticky,
    output logic [ADDRESS_WIDTH-1:0] fault_addr,
    output logic [COUNT_WIDTH-1:0]   load_count,
    output logic [COUNT_WIDTH-1:0]   store_count
);
    localparam int MEM_BYTES = 2 ** MEM_ADDR_BITS;
    typedef logic [MEM_ADDR_BITS-1:0] idx_t;

    logic [7:0] mem_q [MEM_BYTES];

    idx_t idx0, idx1, idx2, idx3;
    logic [7:0] rb0, rb1, rb2, rb3;
    logic access, misaligned, illegal, store_ok, load_ok;

    logic                     fault_sticky_q, fault_sticky_d;
    logic [ADDRESS_WIDTH-1:0] fault_addr_q, fault_addr_d;
    logic [COUNT_WIDTH-1:0]   load_count_q, load_count_d;
    logic [COUNT_WIDTH-1:0]   store_count_q, store_count_d;

    // Upper address bits are dropped, so accesses alias across the whole address space.
    assign idx0 = aluresultm[MEM_ADDR_BITS-1:0];
    assign idx1 = idx0 + idx_t'(1);
    assign idx2 = idx0 + idx_t'(2);
    assign idx3 = idx0 + idx_t'(3);

    assign rb0 = mem_q[idx0];
    assign rb1 = mem_q[idx1];
    assign rb2 = mem_q[idx2];
    assign rb3 = mem_q[idx3];

    always_comb begin
        access = memreadm | memwritem;
        case (funct3m[1:0])
            2'b01:   misaligned = aluresultm[0];
            2'b10:   misaligned = |aluresultm[1:0];
            default: misaligned = 1'b0;
        endcase
        // A combined read+write is judged by the store encoding rules.
        if (memwritem) illegal = funct3m[2] | (funct3m[1:0] == 2'b11);
        else           illegal = (funct3m == 3'b011) | (funct3m[2:1] == 2'b11);
        fault_m  = access & (misaligned | illegal);
        store_ok = memwritem & ~fault_m;
        load_ok  = memreadm & ~memwritem & ~fault_m;
    end

    always_comb begin
        readdatam = '0;
        if (memreadm && !fault_m) begin
            case (funct3m)
                3'b000:  readdatam = {{24{rb0[7]}}, rb0};
                3'b001:  readdatam = {{16{rb1[7]}}, rb1, rb0};
                3'b010:  readdatam = {rb3, rb2, rb1, rb0};
                3'b100:  readdatam = {24'h0, rb0};
                3'b101:  readdatam = {16'h0, rb1, rb0};
                default: readdatam = '0;
            endcase
        end
    end

    // NOTE: the RAM array has no reset branch; clearing it would be impractical and its
    // contents must survive rst. Writes are still suppressed while rst is asserted.
    always_ff @(posedge clk) begin
        if (!rst && store_ok) begin
            mem_q[idx0] <= writedatam[7:0];
            if (funct3m[1:0] != 2'b00) mem_q[idx1] <= writedatam[15:8];
            if (funct3m[1:0] == 2'b10) begin
                mem_q[idx2] <= writedatam[23:16];
                mem_q[idx3] <= writedatam[31:24];
            end
        end
    end

    always_comb begin
        fault_sticky_d = fault_sticky_q | fault_m;
        fault_addr_d   = (fault_m && !fault_sticky_q) ? aluresultm : fault_addr_q;
        store_count_d  = store_count_q;
        load_count_d   = load_count_q;
        if (store_ok && store_count_q != '1) store_count_d = store_count_q + COUNT_WIDTH'(1);
        if (load_ok && load_count_q != '1)   load_count_d  = load_count_q + COUNT_WIDTH'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_sticky_q <= 1'b0;
            fault_addr_q   <= '0;
            load_count_q   <= '0;
            store_count_q  <= '0;
        end else begin
            fault_sticky_q <= fault_sticky_d;
            fault_addr_q   <= fault_addr_d;
            load_count_q   <= load_count_d;
            store_count_q  <= store_count_d;
        end
    end

    assign fault_sticky = fault_sticky_q;
    assign fault_addr   = fault_addr_q;
    assign load_count   = load_count_q;
    assign store_count  = store_count_q;
endmodule
